// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, instruction handshake to
// control, redirect input and fault flag.
interface fetch_unit_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        ins_valid_o;
  logic [31:0] ins_o;
  logic [31:0] ins_pc_o;
  logic        ins_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fault_o;

  modport master (
    output mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_pc_o, fault_o,
    input  mem_ack_i, mem_data_i, ins_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_pc_o, fault_o,
    output mem_ack_i, mem_data_i, ins_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetch: single-outstanding memory reads into a small queue.
// Build option FETCH_ALIGN_CHECK_EN turns misaligned redirects into a sticky HALT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];

  logic             push, pop;
  logic [31:0]      redir_pc;
  logic [31:0]      next_pc;

  assign redir_pc = bus.redirect_pc_i & ~32'h3;
  assign next_pc  = fetch_pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;
  assign misaligned = |bus.redirect_pc_i[1:0];
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d    = fault_q;
`endif

    pop  = !bus.redirect_i && valid_q && bus.ins_ready_i;
    push = !bus.redirect_i && (state_q == REQ) && bus.mem_ack_i;

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      data_d[wr_ptr_q] = bus.mem_data_i;
      pc_d[wr_ptr_q]   = addr_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (bus.redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (misaligned) begin
        // An outstanding read still has to finish on the bus; its data is dropped.
        fault_d = 1'b1;
        state_d = HALT;
        req_d   = req_q && !bus.mem_ack_i;
      end else
`endif
      begin
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = 1'b0;
`endif
        fetch_pc_d = redir_pc;
        if (req_q && !bus.mem_ack_i) begin
          state_d = DRAIN;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = redir_pc;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (count_d < DEPTH_C) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
          end
        end
        REQ: begin
          if (bus.mem_ack_i) begin
            fetch_pc_d = next_pc;
            if (count_d < DEPTH_C) begin
              addr_d = next_pc;
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_ack_i) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        HALT: begin
          if (bus.mem_ack_i) req_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end

    valid_d = (count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      // NOTE: the queue is only DEPTH words, so it is reset to give ins_o/ins_pc_o a defined 0.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign bus.fault_o = fault_q;
`else
  assign bus.fault_o = 1'b0;
`endif

  assign bus.mem_req_o   = req_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.ins_valid_o = valid_q;
  assign bus.ins_o       = data_q[rd_ptr_q];
  assign bus.ins_pc_o    = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2, RESET_PC=0): one cycle per step,
// outputs sampled 1 ns after the rising edge.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ack, input logic [31:0] data,
                      input logic rdy, input logic redir, input logic [31:0] rpc);
    reset             = rst;
    bus.mem_ack_i     = ack;
    bus.mem_data_i    = data;
    bus.ins_ready_i   = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; bus.ins_ready_i = 1'b0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_req",   32'(bus.mem_req_o),   0);
    chk("rst_addr",  bus.mem_addr_o,       0);
    chk("rst_valid", 32'(bus.ins_valid_o), 0);
    chk("rst_ins",   bus.ins_o,            0);
    chk("rst_pc",    bus.ins_pc_o,         0);
    chk("rst_fault", 32'(bus.fault_o),     0);

    // Back-to-back fetch with ready high
    step(0, 0, 0, 1, 0, 0);
    chk("b2b_req1",   32'(bus.mem_req_o),   1);
    chk("b2b_addr0",  bus.mem_addr_o,       32'h0);
    chk("b2b_nvalid", 32'(bus.ins_valid_o), 0);
    step(0, 1, 32'h0, 1, 0, 0);
    chk("b2b_valid0", 32'(bus.ins_valid_o), 1);
    chk("b2b_ins0",   bus.ins_o,            32'h0);
    chk("b2b_pc0",    bus.ins_pc_o,         32'h0);
    chk("b2b_addr4",  bus.mem_addr_o,       32'h4);
    chk("b2b_req_hi", 32'(bus.mem_req_o),   1);
    step(0, 1, 32'h4, 1, 0, 0);
    chk("b2b_ins4",   bus.ins_o,            32'h4);
    chk("b2b_pc4",    bus.ins_pc_o,         32'h4);
    chk("b2b_addr8",  bus.mem_addr_o,       32'h8);
    step(0, 1, 32'h8, 1, 0, 0);
    chk("b2b_ins8",   bus.ins_o,            32'h8);
    chk("b2b_pc8",    bus.ins_pc_o,         32'h8);
    chk("b2b_addrC",  bus.mem_addr_o,       32'hC);

    // Reset mid-request with an ack in the same cycle
    step(1, 1, 32'hC, 0, 0, 0);
    chk("midrst_req",   32'(bus.mem_req_o),   0);
    chk("midrst_valid", 32'(bus.ins_valid_o), 0);
    chk("midrst_addr",  bus.mem_addr_o,       0);

    // Ready low: two acks fill DEPTH=2, then the request drops
    step(0, 0, 0, 0, 0, 0);
    chk("full_addr0", bus.mem_addr_o, 32'h0);
    step(0, 1, 32'h0, 0, 0, 0);
    chk("full_valid", 32'(bus.ins_valid_o), 1);
    chk("full_addr4", bus.mem_addr_o,       32'h4);
    step(0, 1, 32'h4, 0, 0, 0);
    chk("full_reqlo",  32'(bus.mem_req_o), 0);
    chk("full_head0",  bus.ins_o,          32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("full_hold",   32'(bus.mem_req_o), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pop_req",     32'(bus.mem_req_o), 1);
    chk("pop_addr8",   bus.mem_addr_o,     32'h8);
    chk("pop_head4",   bus.ins_o,          32'h4);
    chk("pop_pc4",     bus.ins_pc_o,       32'h4);
    step(0, 0, 0, 0, 0, 0);

    // Redirect during a pending request at 0x8; ack delayed
    step(0, 0, 0, 0, 1, 32'h100);
    chk("drn_valid", 32'(bus.ins_valid_o), 0);
    chk("drn_req",   32'(bus.mem_req_o),   1);
    chk("drn_addr1", bus.mem_addr_o,       32'h8);
    step(0, 0, 0, 0, 0, 0);
    chk("drn_addr2", bus.mem_addr_o, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    chk("drn_addr3", bus.mem_addr_o, 32'h8);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drn_new",    bus.mem_addr_o,       32'h100);
    chk("drn_disc",   32'(bus.ins_valid_o), 0);
    step(0, 1, 32'h100, 0, 0, 0);
    chk("drn_ins",    bus.ins_o,    32'h100);
    chk("drn_inspc",  bus.ins_pc_o, 32'h100);

    // Two entries queued, then redirect with a pop in the same cycle
    step(0, 1, 32'h104, 0, 0, 0);
    chk("two_req_lo", 32'(bus.mem_req_o), 0);
    step(0, 0, 0, 1, 1, 32'h40);
    chk("rp_valid", 32'(bus.ins_valid_o), 0);
    chk("rp_addr",  bus.mem_addr_o,       32'h40);
    step(0, 1, 32'h40, 0, 0, 0);
    chk("rp_ins",   bus.ins_o,    32'h40);
    chk("rp_pc",    bus.ins_pc_o, 32'h40);

    // Wrap-around from 0xFFFF_FFFC (redirect coincides with an ack, which is discarded)
    step(0, 1, 32'h44, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr",  bus.mem_addr_o,       32'hFFFF_FFFC);
    chk("wrap_nval",  32'(bus.ins_valid_o), 0);
    step(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    chk("wrap_pc_hi", bus.ins_pc_o,   32'hFFFF_FFFC);
    chk("wrap_addr0", bus.mem_addr_o, 32'h0);
    step(0, 1, 32'h0, 1, 0, 0);
    chk("wrap_pc0",   bus.ins_pc_o,   32'h0);

    // Misaligned redirect
    step(0, 1, 32'h4, 0, 1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(bus.fault_o),     1);
    chk("mis_req",   32'(bus.mem_req_o),   0);
    chk("mis_valid", 32'(bus.ins_valid_o), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("halt_req",  32'(bus.mem_req_o),   0);
    step(0, 0, 0, 0, 1, 32'h200);
    chk("clr_fault", 32'(bus.fault_o),     0);
    chk("clr_addr",  bus.mem_addr_o,       32'h200);
    step(0, 1, 32'h200, 0, 0, 0);
    chk("clr_pc",    bus.ins_pc_o,         32'h200);
`else
    chk("mis_fault", 32'(bus.fault_o),     0);
    chk("mis_addr",  bus.mem_addr_o,       32'h100);
    chk("mis_req",   32'(bus.mem_req_o),   1);
    step(0, 1, 32'h100, 0, 0, 0);
    chk("mis_pc",    bus.ins_pc_o,         32'h100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
